// File: rtl/level_ctrl_pkg.sv
// level_ctrl_pkg: shared game state encoding and level limits
package level_ctrl_pkg;
  localparam int LEVEL_W = 4;
  localparam int MAX_LEVEL = 9;
  typedef enum logic [2:0] {IDLE, PLAY, LEVEL_UP, HIT, GAME_OVER, VICTORY} state_t;
endpackage

// File: rtl/level_ctrl_pause_timer.sv
// pause_timer: counts pause cycles, done on the last cycle of the pause
module pause_timer #(
  parameter int C_CYCLES = 4
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int W = $clog2(C_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge i_Clk)
    cnt <= (!i_Rst_n || clr) ? '0 : en ? cnt + W'(1) : cnt;
  assign done = en && cnt == W'(C_CYCLES - 1);
endmodule

// File: rtl/level_ctrl.sv
// level_ctrl: game flow FSM for levels, lives, pauses and frog resets
module level_ctrl
  import level_ctrl_pkg::*;
#(
  parameter int C_LIVES = 3,
  parameter int C_MAX_LEVEL = MAX_LEVEL,
  parameter int C_PAUSE_CYCLES = 25000000
) (
  input  logic               i_Clk,
  input  logic               i_Rst_n,
  input  logic               i_start,
  input  logic               i_goal,
  input  logic               i_collision,
  output logic [LEVEL_W-1:0] o_level,
  output logic [1:0]         o_lives,
  output logic               o_freeze,
  output logic               o_frog_reset,
  output logic               o_game_over,
  output logic               o_victory
);
  state_t state;
  logic pausing, done;
  assign pausing = state == HIT || state == LEVEL_UP;
  pause_timer #(.C_CYCLES(C_PAUSE_CYCLES)) u_pause (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .clr(!pausing), .en(pausing), .done(done)
  );
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state <= IDLE;
      o_level <= LEVEL_W'(1);
      o_lives <= 2'(C_LIVES);
      o_freeze <= 1'b1;
      o_frog_reset <= 1'b0;
      o_game_over <= 1'b0;
      o_victory <= 1'b0;
    end else begin
      o_frog_reset <= 1'b0;
      case (state)
        IDLE, GAME_OVER, VICTORY:
          if (i_start) begin
            state <= PLAY;
            o_level <= LEVEL_W'(1);
            o_lives <= 2'(C_LIVES);
            o_freeze <= 1'b0;
            o_frog_reset <= 1'b1;
            o_game_over <= 1'b0;
            o_victory <= 1'b0;
          end
        PLAY:
          if (i_collision) begin
            state <= HIT;
            o_lives <= o_lives - {1'b0, |o_lives};
            o_freeze <= 1'b1;
          end else if (i_goal) begin
            o_freeze <= 1'b1;
            if (o_level >= LEVEL_W'(C_MAX_LEVEL)) begin
              state <= VICTORY;
              o_victory <= 1'b1;
            end else begin
              state <= LEVEL_UP;
              o_level <= o_level + LEVEL_W'(1);
            end
          end
        HIT:
          if (done) begin
            if (o_lives == 2'd0) begin
              state <= GAME_OVER;
              o_game_over <= 1'b1;
            end else begin
              state <= PLAY;
              o_freeze <= 1'b0;
              o_frog_reset <= 1'b1;
            end
          end
        LEVEL_UP:
          if (done) begin
            state <= PLAY;
            o_freeze <= 1'b0;
            o_frog_reset <= 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_level_ctrl.sv
// tb_level_ctrl: scoreboard bench for level_ctrl with a 4-cycle pause
module tb_level_ctrl;
  logic i_Clk = 1'b0, i_Rst_n = 1'b0, i_start = 1'b0, i_goal = 1'b0, i_collision = 1'b0;
  logic [3:0] o_level;
  logic [1:0] o_lives;
  logic o_freeze, o_frog_reset, o_game_over, o_victory;
  int n_chk = 0, n_pass = 0;
  typedef struct {string tag; logic [9:0] val;} exp_t;
  exp_t q[$];
  level_ctrl #(.C_LIVES(3), .C_MAX_LEVEL(9), .C_PAUSE_CYCLES(4)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_start(i_start), .i_goal(i_goal),
    .i_collision(i_collision), .o_level(o_level), .o_lives(o_lives), .o_freeze(o_freeze),
    .o_frog_reset(o_frog_reset), .o_game_over(o_game_over), .o_victory(o_victory)
  );
  always #5 i_Clk = ~i_Clk;
  function automatic logic [9:0] pk(int l, int v, logic f, logic fr, logic go, logic vi);
    return {4'(l), 2'(v), f, fr, go, vi};
  endfunction
  task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got lvl=%0d lives=%0d fz/fr/go/vi=%b, expected lvl=%0d lives=%0d fz/fr/go/vi=%b",
                  tag, got[9:6], got[5:4], got[3:0], exp[9:6], exp[5:4], exp[3:0]);
  endtask
  task automatic step(input logic rn, input logic s, input logic g, input logic c,
                      input logic [9:0] e, input string tag);
    exp_t x;
    @(negedge i_Clk);
    i_Rst_n = rn; i_start = s; i_goal = g; i_collision = c;
    q.push_back('{tag, e});
    @(posedge i_Clk);
    #1;
    x = q.pop_front();
    check(x.tag, {o_level, o_lives, o_freeze, o_frog_reset, o_game_over, o_victory}, x.val);
  endtask
  task automatic lvl_up(input int from, input int lv);
    step(1, 0, 1, 0, pk(from + 1, lv, 1, 0, 0, 0), $sformatf("goal_l%0d", from));
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 1, pk(from + 1, lv, 1, 0, 0, 0), $sformatf("lu_pause_l%0d_%0d", from, i));
    step(1, 0, 0, 0, pk(from + 1, lv, 0, 1, 0, 0), $sformatf("lu_exit_l%0d", from));
  endtask
  task automatic hit(input int lvl, input int lv, input logic g);
    step(1, 0, g, 1, pk(lvl, lv, 1, 0, 0, 0), $sformatf("hit_lv%0d", lv));
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 1, pk(lvl, lv, 1, 0, 0, 0), $sformatf("hit_pause_lv%0d_%0d", lv, i));
    step(1, 0, 0, 0, lv == 0 ? pk(lvl, 0, 1, 0, 1, 0) : pk(lvl, lv, 0, 1, 0, 0),
         $sformatf("hit_exit_lv%0d", lv));
  endtask
  initial begin
    step(0, 0, 0, 0, pk(1, 3, 1, 0, 0, 0), "reset");
    step(1, 0, 1, 1, pk(1, 3, 1, 0, 0, 0), "idle_hold");
    step(1, 1, 0, 0, pk(1, 3, 0, 1, 0, 0), "start");
    step(1, 0, 0, 0, pk(1, 3, 0, 0, 0, 0), "play");
    step(1, 1, 0, 0, pk(1, 3, 0, 0, 0, 0), "start_ignored");
    lvl_up(1, 3);
    step(1, 0, 0, 0, pk(2, 3, 0, 0, 0, 0), "play_l2");
    hit(2, 2, 0);
    hit(2, 1, 0);
    hit(2, 0, 0);
    step(1, 0, 1, 1, pk(2, 0, 1, 0, 1, 0), "over_hold");
    step(1, 1, 0, 0, pk(1, 3, 0, 1, 0, 0), "restart");
    for (int l = 1; l < 4; l++) lvl_up(l, 3);
    hit(4, 2, 1);
    step(1, 0, 1, 0, pk(5, 2, 1, 0, 0, 0), "goal_l4_b");
    step(1, 0, 0, 0, pk(5, 2, 1, 0, 0, 0), "lu_cycle2");
    step(0, 0, 0, 0, pk(1, 3, 1, 0, 0, 0), "mid_pause_reset");
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, pk(1, 3, 1, 0, 0, 0), $sformatf("post_reset_%0d", i));
    step(1, 1, 0, 0, pk(1, 3, 0, 1, 0, 0), "start2");
    for (int l = 1; l < 9; l++) lvl_up(l, 3);
    step(1, 0, 1, 0, pk(9, 3, 1, 0, 0, 1), "victory");
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, pk(9, 3, 1, 0, 0, 1), $sformatf("victory_hold_%0d", i));
    step(1, 1, 0, 0, pk(1, 3, 0, 1, 0, 0), "restart_victory");
    step(1, 0, 0, 0, pk(1, 3, 0, 0, 0, 0), "play_final");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
